// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised pipeline stage: defaults, occupancy
// encoding and the 8 x 32-bit payload field layout.
package pipe_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned EXC_W_DEF = 5;

    localparam logic [PC_W-1:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [PC_W-1:0] PC_EXC_DEF   = 32'h0000_4180;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Payload field layout when DATA_W = 256
    localparam int unsigned FLD_W     = 32;
    localparam int unsigned OFF_INSTR = 0;
    localparam int unsigned OFF_PC8   = 32;
    localparam int unsigned OFF_EXT   = 64;
    localparam int unsigned OFF_RD1   = 96;
    localparam int unsigned OFF_RD2   = 128;
    localparam int unsigned OFF_ALU   = 160;
    localparam int unsigned OFF_MDU   = 192;
    localparam int unsigned OFF_SPARE = 224;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready pipeline link carrying pc, payload, exception code and delay-slot bit.
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned EXC_W  = EXC_W_DEF
) ();

    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;

    modport master (output valid, pc, data, exc, bd, input ready);
    modport slave  (input valid, pc, data, exc, bd, output ready);

endinterface

// File: rtl/pipe_slot.sv
// One loadable pipeline entry. Priority: reset > flush (load exception PC) >
// kill (drop entry, keep pc) > load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned     DATA_W   = 256,
    parameter int unsigned     EXC_W    = EXC_W_DEF,
    parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEF,
    parameter logic [PC_W-1:0] PC_EXC   = PC_EXC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              kill,
    input  logic              load,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [DATA_W-1:0] d_data,
    input  logic [EXC_W-1:0]  d_exc,
    input  logic              d_bd,
    output logic              q_valid,
    output logic [PC_W-1:0]   q_pc,
    output logic [DATA_W-1:0] q_data,
    output logic [EXC_W-1:0]  q_exc,
    output logic              q_bd
);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q,    pc_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [EXC_W-1:0]  exc_q,   exc_d;
    logic              bd_q,    bd_d;

    // An invalid entry always carries zero data/exc/bd
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = PC_EXC;
            data_d  = '0;
            exc_d   = '0;
            bd_d    = 1'b0;
        end else if (kill) begin
            valid_d = 1'b0;
            data_d  = '0;
            exc_d   = '0;
            bd_d    = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = d_pc;
            data_d  = d_data;
            exc_d   = d_exc;
            bd_d    = d_bd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= PC_RESET;
            data_q  <= '0;
            exc_q   <= '0;
            bd_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
        end
    end

    assign q_valid = valid_q;
    assign q_pc    = pc_q;
    assign q_data  = data_q;
    assign q_exc   = exc_q;
    assign q_bd    = bd_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with optional 2-entry skid buffer, exception flush,
// bubble insert and a saturating stall counter.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned     DATA_W   = 256,
    parameter int unsigned     EXC_W    = EXC_W_DEF,
    parameter logic [PC_W-1:0] PC_RESET = PC_RESET_DEF,
    parameter logic [PC_W-1:0] PC_EXC   = PC_EXC_DEF,
    parameter int unsigned     SKID     = 1,
    parameter int unsigned     STALL_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                clr,
    pipe_stage_skid_if.slave    up,
    pipe_stage_skid_if.master   dn,
    output logic [1:0]          occupancy,
    output logic [STALL_W-1:0]  stall_cnt
);

    localparam bit HAS_SKID = (SKID != 0);

    occ_e occ_q, occ_d;
    logic in_ready_q, in_ready_d;
    logic in_ready_c;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic accept, emit;
    logic head_valid, head_load, head_kill, head_from_skid;
    logic skid_valid, skid_bd;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic [EXC_W-1:0]  skid_exc;

    assign in_ready_c = HAS_SKID ? in_ready_q : (dn.ready | ~head_valid);
    assign up.ready   = in_ready_c;
    assign accept     = up.valid & in_ready_c;
    assign emit       = head_valid & dn.ready;

    // Occupancy FSM; flush and clear empty both slots in one cycle
    always_comb begin
        occ_d          = occ_q;
        head_load      = 1'b0;
        head_kill      = 1'b0;
        head_from_skid = 1'b0;
        if (req || clr) begin
            occ_d = OCC_EMPTY;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d     = OCC_ONE;
                        head_load = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && (emit || !HAS_SKID)) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        occ_d = OCC_TWO;
                    end else if (emit) begin
                        occ_d     = OCC_EMPTY;
                        head_kill = 1'b1;
                    end
                end
                OCC_TWO: begin
                    if (emit && skid_valid) begin
                        occ_d          = OCC_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: occ_d = OCC_EMPTY;
            endcase
        end
        in_ready_d = (occ_d != OCC_TWO);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            occ_q      <= occ_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Saturating stall counter, frozen during flush/clear cycles
    always_comb begin
        stall_d = stall_q;
        if (!req && !clr && head_valid && !dn.ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    pipe_slot #(
        .DATA_W   (DATA_W),
        .EXC_W    (EXC_W),
        .PC_RESET (PC_RESET),
        .PC_EXC   (PC_EXC)
    ) u_head (
        .clk     (clk),
        .reset   (reset),
        .flush   (req),
        .kill    (clr | head_kill),
        .load    (head_load),
        .d_pc    (head_from_skid ? skid_pc   : up.pc),
        .d_data  (head_from_skid ? skid_data : up.data),
        .d_exc   (head_from_skid ? skid_exc  : up.exc),
        .d_bd    (head_from_skid ? skid_bd   : up.bd),
        .q_valid (head_valid),
        .q_pc    (dn.pc),
        .q_data  (dn.data),
        .q_exc   (dn.exc),
        .q_bd    (dn.bd)
    );

    generate
        if (HAS_SKID) begin : g_skid
            logic skid_load;
            // Skid captures the input only when the head is full and stalled
            assign skid_load = (occ_q == OCC_ONE) && accept && !emit;

            pipe_slot #(
                .DATA_W   (DATA_W),
                .EXC_W    (EXC_W),
                .PC_RESET (PC_RESET),
                .PC_EXC   (PC_EXC)
            ) u_skid (
                .clk     (clk),
                .reset   (reset),
                .flush   (req),
                .kill    (clr | head_from_skid),
                .load    (skid_load),
                .d_pc    (up.pc),
                .d_data  (up.data),
                .d_exc   (up.exc),
                .d_bd    (up.bd),
                .q_valid (skid_valid),
                .q_pc    (skid_pc),
                .q_data  (skid_data),
                .q_exc   (skid_exc),
                .q_bd    (skid_bd)
            );
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_pc    = '0;
            assign skid_data  = '0;
            assign skid_exc   = '0;
            assign skid_bd    = 1'b0;
        end
    endgenerate

    assign dn.valid  = head_valid;
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: skid build, 4-bit stall-counter build and single-register build.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int unsigned DW = 256;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // a_*: SKID=1, STALL_W=16
    logic a_req, a_clr;
    logic [1:0]  a_occ;
    logic [15:0] a_stall;
    pipe_stage_skid_if #(.DATA_W(DW), .EXC_W(5)) a_up ();
    pipe_stage_skid_if #(.DATA_W(DW), .EXC_W(5)) a_dn ();
    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .STALL_W(16)) u_a (
        .clk(clk), .reset(reset), .req(a_req), .clr(a_clr),
        .up(a_up), .dn(a_dn), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    // s_*: SKID=1, STALL_W=4
    logic s_req, s_clr;
    logic [1:0] s_occ;
    logic [3:0] s_stall;
    pipe_stage_skid_if #(.DATA_W(DW), .EXC_W(5)) s_up ();
    pipe_stage_skid_if #(.DATA_W(DW), .EXC_W(5)) s_dn ();
    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .STALL_W(4)) u_s (
        .clk(clk), .reset(reset), .req(s_req), .clr(s_clr),
        .up(s_up), .dn(s_dn), .occupancy(s_occ), .stall_cnt(s_stall)
    );

    // n_*: SKID=0
    logic n_req, n_clr;
    logic [1:0]  n_occ;
    logic [15:0] n_stall;
    pipe_stage_skid_if #(.DATA_W(DW), .EXC_W(5)) n_up ();
    pipe_stage_skid_if #(.DATA_W(DW), .EXC_W(5)) n_dn ();
    pipe_stage_skid #(.DATA_W(DW), .SKID(0), .STALL_W(16)) u_n (
        .clk(clk), .reset(reset), .req(n_req), .clr(n_clr),
        .up(n_up), .dn(n_dn), .occupancy(n_occ), .stall_cnt(n_stall)
    );

    function automatic logic [DW-1:0] mk(input logic [31:0] pc);
        logic [DW-1:0] d;
        d = '0;
        d[OFF_INSTR +: FLD_W] = 32'hC0DE_0000 | {16'h0, pc[15:0]};
        d[OFF_PC8   +: FLD_W] = pc + 32'd8;
        d[OFF_ALU   +: FLD_W] = ~pc;
        d[OFF_SPARE +: FLD_W] = 32'hA5A5_0000 | {16'h0, pc[15:0]};
        return d;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_push(input logic v, input logic [31:0] pc, input logic [4:0] exc, input logic bd);
        a_up.valid = v;
        a_up.pc    = pc;
        a_up.data  = v ? mk(pc) : '0;
        a_up.exc   = exc;
        a_up.bd    = bd;
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; a_clr = 1'b0; s_req = 1'b0; s_clr = 1'b0; n_req = 1'b0; n_clr = 1'b0;
        a_push(1'b0, 32'h0, 5'd0, 1'b0);
        a_dn.ready = 1'b1;
        s_up.valid = 1'b0; s_up.pc = '0; s_up.data = '0; s_up.exc = '0; s_up.bd = 1'b0; s_dn.ready = 1'b0;
        n_up.valid = 1'b0; n_up.pc = '0; n_up.data = '0; n_up.exc = '0; n_up.bd = 1'b0; n_dn.ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_pc",    256'(a_dn.pc),    256'(32'h3000));
        chk("rst_valid", 256'(a_dn.valid), 256'(0));
        chk("rst_ready", 256'(a_up.ready), 256'(1));
        chk("rst_occ",   256'(a_occ),      256'(0));
        chk("rst_stall", 256'(a_stall),    256'(0));
        chk("rst_data",  a_dn.data,        256'(0));

        // Streaming with out_ready=1
        a_push(1'b1, 32'h3000, 5'd0, 1'b0);
        tick();
        chk("st0_pc",  256'(a_dn.pc),    256'(32'h3000));
        chk("st0_v",   256'(a_dn.valid), 256'(1));
        chk("st0_occ", 256'(a_occ),      256'(1));
        a_push(1'b1, 32'h3004, 5'd0, 1'b0);
        tick();
        chk("st1_pc",  256'(a_dn.pc), 256'(32'h3004));
        chk("st1_occ", 256'(a_occ),   256'(1));
        a_push(1'b1, 32'h3008, 5'd0, 1'b0);
        tick();
        chk("st2_pc",   256'(a_dn.pc), 256'(32'h3008));
        chk("st2_data", a_dn.data,     mk(32'h3008));
        chk("st2_occ",  256'(a_occ),   256'(1));
        a_push(1'b0, 32'h0, 5'd0, 1'b0);
        tick();
        chk("st3_v",     256'(a_dn.valid), 256'(0));
        chk("st3_data",  a_dn.data,        256'(0));
        chk("st3_occ",   256'(a_occ),      256'(0));
        chk("st3_stall", 256'(a_stall),    256'(0));

        // Backpressure into the skid slot
        a_dn.ready = 1'b0;
        a_push(1'b1, 32'h3100, 5'd0, 1'b0);
        tick();
        chk("bp_a_occ", 256'(a_occ),      256'(1));
        chk("bp_a_rdy", 256'(a_up.ready), 256'(1));
        a_push(1'b1, 32'h3104, 5'd2, 1'b1);
        tick();
        chk("bp_b_occ",   256'(a_occ),      256'(2));
        chk("bp_b_rdy",   256'(a_up.ready), 256'(0));
        chk("bp_b_pc",    256'(a_dn.pc),    256'(32'h3100));
        chk("bp_b_stall", 256'(a_stall),    256'(1));
        a_push(1'b1, 32'h3108, 5'd0, 1'b0);
        tick();
        chk("bp_hold_occ", 256'(a_occ),   256'(2));
        chk("bp_hold_pc",  256'(a_dn.pc), 256'(32'h3100));
        a_push(1'b0, 32'h0, 5'd0, 1'b0);
        a_dn.ready = 1'b1;
        tick();
        chk("bp_e1_pc",  256'(a_dn.pc),    256'(32'h3104));
        chk("bp_e1_exc", 256'(a_dn.exc),   256'(2));
        chk("bp_e1_bd",  256'(a_dn.bd),    256'(1));
        chk("bp_e1_dat", a_dn.data,        mk(32'h3104));
        chk("bp_e1_occ", 256'(a_occ),      256'(1));
        chk("bp_e1_rdy", 256'(a_up.ready), 256'(1));
        tick();
        chk("bp_e2_v",     256'(a_dn.valid), 256'(0));
        chk("bp_e2_occ",   256'(a_occ),      256'(0));
        chk("bp_e2_stall", 256'(a_stall),    256'(2));

        // Exception flush while full, with a same-cycle input
        a_dn.ready = 1'b0;
        a_push(1'b1, 32'h3200, 5'd0, 1'b0);
        tick();
        a_push(1'b1, 32'h3204, 5'd0, 1'b0);
        tick();
        chk("ex_pre_occ", 256'(a_occ), 256'(2));
        a_req = 1'b1;
        a_push(1'b1, 32'h3208, 5'd1, 1'b1);
        tick();
        a_req = 1'b0;
        a_push(1'b0, 32'h0, 5'd0, 1'b0);
        chk("ex_v",     256'(a_dn.valid), 256'(0));
        chk("ex_pc",    256'(a_dn.pc),    256'(32'h4180));
        chk("ex_occ",   256'(a_occ),      256'(0));
        chk("ex_rdy",   256'(a_up.ready), 256'(1));
        chk("ex_stall", 256'(a_stall),    256'(3));
        tick();
        chk("ex_drop_v",  256'(a_dn.valid), 256'(0));
        chk("ex_drop_pc", 256'(a_dn.pc),    256'(32'h4180));

        // Bubble insert keeps pc, zeroes the rest
        a_push(1'b1, 32'h3010, 5'd4, 1'b1);
        tick();
        chk("clr_pre_exc", 256'(a_dn.exc), 256'(4));
        a_clr = 1'b1;
        a_push(1'b1, 32'h3014, 5'd4, 1'b1);
        tick();
        a_clr = 1'b0;
        a_push(1'b0, 32'h0, 5'd0, 1'b0);
        chk("clr_v",     256'(a_dn.valid), 256'(0));
        chk("clr_pc",    256'(a_dn.pc),    256'(32'h3010));
        chk("clr_exc",   256'(a_dn.exc),   256'(0));
        chk("clr_bd",    256'(a_dn.bd),    256'(0));
        chk("clr_occ",   256'(a_occ),      256'(0));
        chk("clr_stall", 256'(a_stall),    256'(3));

        // Reset while full
        a_push(1'b1, 32'h3300, 5'd0, 1'b0);
        tick();
        a_push(1'b1, 32'h3304, 5'd0, 1'b0);
        tick();
        a_push(1'b0, 32'h0, 5'd0, 1'b0);
        chk("rs_pre_occ", 256'(a_occ), 256'(2));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_occ",   256'(a_occ),      256'(0));
        chk("rs_pc",    256'(a_dn.pc),    256'(32'h3000));
        chk("rs_v",     256'(a_dn.valid), 256'(0));
        chk("rs_stall", 256'(a_stall),    256'(0));
        chk("rs_rdy",   256'(a_up.ready), 256'(1));

        // Stall counter saturation (4-bit)
        s_up.valid = 1'b1; s_up.pc = 32'h3400; s_up.data = mk(32'h3400);
        tick();
        s_up.valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("sat_14", 256'(s_stall), 256'(14));
        for (int i = 0; i < 6; i++) tick();
        chk("sat_15", 256'(s_stall), 256'(15));
        for (int i = 0; i < 3; i++) tick();
        chk("sat_hold", 256'(s_stall), 256'(15));
        chk("sat_v",    256'(s_dn.valid), 256'(1));

        // Single-register build: combinational in_ready
        chk("ns_rdy0", 256'(n_up.ready), 256'(1));
        n_up.valid = 1'b1; n_up.pc = 32'h3000; n_up.data = mk(32'h3000);
        tick();
        chk("ns0_pc",  256'(n_dn.pc), 256'(32'h3000));
        chk("ns0_occ", 256'(n_occ),   256'(1));
        n_dn.ready = 1'b0;
        #1;
        chk("ns_rdy_lo", 256'(n_up.ready), 256'(0));
        n_dn.ready = 1'b1;
        #1;
        chk("ns_rdy_hi", 256'(n_up.ready), 256'(1));
        n_up.pc = 32'h3004; n_up.data = mk(32'h3004);
        tick();
        chk("ns1_pc", 256'(n_dn.pc), 256'(32'h3004));
        n_up.pc = 32'h3008; n_up.data = mk(32'h3008);
        tick();
        chk("ns2_pc", 256'(n_dn.pc), 256'(32'h3008));
        n_dn.ready = 1'b0;
        n_up.pc = 32'h300C; n_up.data = mk(32'h300C);
        tick();
        chk("ns_bp_pc",  256'(n_dn.pc), 256'(32'h3008));
        chk("ns_bp_occ", 256'(n_occ),   256'(1));
        n_dn.ready = 1'b1;
        tick();
        n_up.valid = 1'b0;
        chk("ns3_pc",   256'(n_dn.pc), 256'(32'h300C));
        chk("ns3_data", n_dn.data,     mk(32'h300C));
        tick();
        chk("ns4_v",   256'(n_dn.valid), 256'(0));
        chk("ns4_occ", 256'(n_occ),      256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed per-stage pipeline registers (E->M style).
- Carries a configurable payload, plus PC, exception code and branch-delay bit, under a valid/ready handshake. Optionally adds a 2-entry skid buffer, so backpressure does not need a combinational ready path.
- Supports exception flush with vector-PC load, bubble-insert clear, and a saturating stall counter for performance monitoring.
- Sits between any two pipeline stages of the CPU.

Parameters:
- DATA_W, 256, payload width (e.g. 8 x 32-bit fields: instr, pc8, ext, RD1, RD2, alu, mdu, spare).
- EXC_W, 5, exception-code width.
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- PC_EXC, 32'h0000_4180, PC value loaded on exception request.
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register (in_ready = out_ready | ~out_valid).
- STALL_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  1  exception flush: kill contents, load PC_EXC
- clr  in  1  bubble insert: kill contents, keep out_pc
- in_valid  in  1  upstream entry valid
- in_ready  out  1  this stage accepts an entry this cycle
- in_pc  in  32  upstream PC
- in_data  in  DATA_W  upstream payload
- in_exc  in  EXC_W  upstream exception code
- in_bd  in  1  upstream branch-delay flag
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head this cycle
- out_pc  out  32  head PC
- out_data  out  DATA_W  head payload
- out_exc  out  EXC_W  head exception code
- out_bd  out  1  head branch-delay flag
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)
- stall_cnt  out  STALL_W  cycles with out_valid & ~out_ready, saturating

Behaviour:
- Priority per cycle: reset > req > clr > handshake.
- Reset: out_valid=0, out_pc=PC_RESET, out_data=0, out_exc=0, out_bd=0, skid slot empty, occupancy=0, stall_cnt=0. in_ready=1 in the cycle after reset.
- req: same as reset except out_pc=PC_EXC. stall_cnt is held. An accept of an in_valid entry in the same cycle is discarded.
- clr: out_valid=0; data, exc and bd go to 0; out_pc holds; skid is emptied. Same-cycle input is discarded; stall_cnt is held.
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready. All outputs are registered except in_ready when SKID=0.
- SKID=1 state machine (occupancy):
  - EMPTY -accept-> ONE (head loads input).
  - ONE: accept & emit -> ONE (head reloads); accept & ~emit -> TWO (skid loads); emit & ~accept -> EMPTY.
  - TWO: emit -> ONE (head loads skid). No accept is possible.
  - in_ready = (occupancy != 2), registered.
- SKID=0: in_ready = out_ready | ~out_valid. The head loads on accept and goes to EMPTY on emit without accept. occupancy is never 2.
- Ordering: entries emit strictly in acceptance order, with no duplication or loss. The skid entry always emits after the head.
- Latency: 1 cycle from accept to out_valid when empty.
- When out_valid=0, out_data, out_exc and out_bd are 0.
- stall_cnt increments when out_valid & ~out_ready and saturates at all-ones (no wrap). It clears only on reset.
- Reset or req asserted mid-stall (occupancy=2) empties both slots in one cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - EXC_W default, PC_RESET, PC_EXC;
  - the occupancy state encoding (OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2);
  - the payload field offsets for the 8 x 32 layout.
- One natural sub-module, pipe_slot: a single loadable entry (pc/data/exc/bd/valid) with load, kill and kill-with-PC inputs. It is instantiated as head, and as skid when SKID=1.

Test Plan:
- Reset then idle: out_pc=32'h3000, out_valid=0, in_ready=1, occupancy=0, stall_cnt=0.
- Stream with out_ready=1: push pc 0x3000, 0x3004, 0x3008 on consecutive cycles -> each appears 1 cycle later, in order; occupancy stays 1.
- Backpressure (SKID=1): out_ready=0, push A then B -> occupancy=2 and in_ready=0. Then out_ready=1 for 2 cycles -> A then B emitted; stall_cnt equals the number of stalled cycles.
- Exception: occupancy=2, assert req together with in_valid -> next cycle out_valid=0, out_pc=32'h4180, occupancy=0, and the input is dropped.
- clr with head pc=0x3010, in_exc=5'd4 pending -> out_valid=0, out_pc=0x3010, out_exc=0, bd=0.
- Saturation: STALL_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=15 and holds there. SKID=0 build repeats the streaming test with in_ready following out_ready combinationally.
